uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 200: clk_3125 cycles allowed from tx_start to tx_done before abort (one frame at division 14 is 154 cycles).
REQ-003 Parameter GAP, default 2: idle cycles forced between frames.
REQ-004 clk_3125  in  1  sole clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 req_valid  in  N_REQ  per-requester frame request, held until req_ack.
REQ-007 req_data  in  8*N_REQ  payload; requester i uses bits [8i+7:8i].
REQ-008 req_parity  in  N_REQ  per-requester parity type (0 even, 1 odd).
REQ-009 req_ack  out  N_REQ  one-cycle one-hot pulse: payload captured.
REQ-010 req_done  out  N_REQ  one-cycle one-hot pulse: frame finished (tx_done seen).
REQ-011 req_err  out  N_REQ  one-cycle one-hot pulse: frame aborted on timeout.
REQ-012 tx_start  out  1  start strobe to the UART transmitter.
REQ-013 tx_data  out  8  byte to the transmitter, registered.
REQ-014 tx_parity_type  out  1  parity selection to the transmitter, registered.
REQ-015 tx_done  in  1  one-cycle frame-complete pulse from the transmitter.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 owner  out  3  index of the current/last granted requester.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, GAP; GAP is unused and skipped when GAP=0.
REQ-019 IDLE: if any req_valid, grant the round-robin winner; in the same edge latch its data/parity into tx_data/tx_parity_type, set owner, pulse req_ack[winner], go ISSUE.
REQ-020 Round robin: search starts at owner+1 modulo N_REQ; after reset owner=N_REQ-1, so requester 0 has first priority.
REQ-021 ISSUE: tx_start=1 for exactly one cycle; go WAIT; clear the timeout counter.
REQ-022 WAIT: tx_start=0; tx_done=1 -> pulse req_done[owner], go GAP; counter reaching TIMEOUT-1 without tx_done -> pulse req_err[owner], go GAP.
REQ-023 GAP: count GAP cycles, then IDLE; requests are not granted during GAP.
REQ-024 tx_data/tx_parity_type stay stable from ISSUE until the next grant.
REQ-025 tx_done outside WAIT is ignored; no req_done pulse.
REQ-026 tx_done and timeout on the same edge: tx_done wins; req_done, not req_err.
REQ-027 Requester dropping req_valid before ack is legal; it is not granted.
REQ-028 req_ack, req_done, req_err are each at most one-hot and never asserted together.
REQ-029 Grant-to-start latency: 1 cycle; frame-to-frame minimum spacing: tx_done + GAP + 2 cycles.
REQ-030 Timeout counter is ceil(log2(TIMEOUT+1)) bits wide and does not wrap.

Reset
REQ-031 rst_n low: state=IDLE, tx_start=0, tx_data=8'h00, tx_parity_type=0, req_ack/req_done/req_err=0, busy=0, owner=N_REQ-1, counters=0.
REQ-032 Reset mid-frame aborts silently with no req_done or req_err; the first grant follows rst_n high by at least one edge.

Structure
REQ-033 Shared package uart_pkg holds the FSM state encoding, the default baud division (14), and the frame-length constant (11 bits).
REQ-034 One sub-module rr_arbiter (N_REQ request vector plus pointer in, one-hot grant plus index out, combinational).
REQ-035 The top level instantiates no uart_tx; integration wires tx_start/tx_data/tx_parity_type/tx_done to it.

Verification
REQ-036 Single request: req_valid=4'b0100, data 8'hA5, parity 1 -> req_ack=4'b0100 next edge, tx_start one cycle later, tx_data=A5, req_done[2] on the tx_done pulse.
REQ-037 All four requesting continuously after reset -> grants 0,1,2,3,0 in order, each separated by at least GAP idle cycles.
REQ-038 Transmitter stub never returns tx_done -> req_err[owner] exactly TIMEOUT cycles after tx_start, then GAP cycles, then the next grant.
REQ-039 tx_done on the timeout edge -> req_done only; a spurious tx_done in IDLE -> no output pulse.
REQ-040 rst_n low during WAIT -> all outputs at reset values immediately, no done/err pulse, owner=3; after release requester 0 is granted first.
REQ-041 Bench with real uart_tx (division 14): byte 8'h3C, even parity -> line shows start bit, bits 7..0 MSB-first, parity 0, stop bit, 14 cycles each.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   arb_state_e : arbiter FSM state encoding (IDLE, ISSUE, WAIT, GAP)
//   BaudDiv     : default clk_3125 cycles per UART bit
//   FrameBits   : bits per frame (start + 8 data + parity + stop)
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StGap   = 2'd3
    } arb_state_e;

    localparam int unsigned BaudDiv   = 14;
    localparam int unsigned FrameBits = 11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector, one bit per requester
//   ptr         : index of the last granted requester; search starts at ptr+1
//   grant       : one-hot grant (all zero when no request)
//   grant_idx   : index of the granted requester
//   grant_valid : at least one request present
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic             grant_valid
);

    int unsigned cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        // Walk ptr+1, ptr+2, ... wrapping, ending on ptr itself.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = 3'(cand);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
//   clk_3125       : sole clock
//   rst_n          : asynchronous active-low reset
//   req_valid      : per-requester frame request, held until req_ack
//   req_data       : payloads, requester i on bits [8i+7:8i]
//   req_parity     : per-requester parity type (0 even, 1 odd)
//   req_ack        : one-hot pulse, payload captured
//   req_done       : one-hot pulse, frame finished
//   req_err        : one-hot pulse, frame aborted on timeout
//   tx_start       : one-cycle start strobe to the transmitter
//   tx_data        : byte to the transmitter, stable until the next grant
//   tx_parity_type : parity selection to the transmitter
//   tx_done        : frame-complete pulse from the transmitter
//   busy           : high whenever the FSM is not idle
//   owner          : current/last granted requester
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned GAP     = 2
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_parity,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_err,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 tx_parity_type,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           owner
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    arb_state_e         state_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic [N_REQ-1:0]   win_grant;
    logic [2:0]         win_idx;
    logic               win_valid;
    logic [7:0]         sel_data;
    logic               sel_parity;
    logic [N_REQ-1:0]   owner_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (owner),
        .grant       (win_grant),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    // Payload mux driven by the one-hot grant, avoids variable-width indexing.
    always_comb begin
        sel_data   = '0;
        sel_parity = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_grant[i]) begin
                sel_data   = req_data[8*i +: 8];
                sel_parity = req_parity[i];
            end
        end
    end

    assign owner_onehot = N_REQ'(1) << owner;

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            tmo_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            req_ack        <= '0;
            req_done       <= '0;
            req_err        <= '0;
            tx_start       <= 1'b0;
            tx_data        <= 8'h00;
            tx_parity_type <= 1'b0;
            busy           <= 1'b0;
            owner          <= 3'(N_REQ - 1);
        end else begin
            // Pulses last exactly one cycle.
            req_ack  <= '0;
            req_done <= '0;
            req_err  <= '0;
            tx_start <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        tx_data        <= sel_data;
                        tx_parity_type <= sel_parity;
                        owner          <= win_idx;
                        req_ack        <= win_grant;
                        busy           <= 1'b1;
                        state_q        <= StIssue;
                    end
                end

                StIssue: begin
                    tx_start  <= 1'b1;
                    tmo_cnt_q <= '0;
                    state_q   <= StWait;
                end

                StWait: begin
                    // tx_done has priority over a coincident timeout.
                    if (tx_done || tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        if (tx_done) begin
                            req_done <= owner_onehot;
                        end else begin
                            req_err <= owner_onehot;
                        end
                        gap_cnt_q <= '0;
                        if (GAP == 0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= StGap;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                        gap_cnt_q <= '0;
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
